jtpang_pcm_romcache: RTL



---
 rtl/jtpang_pcm_romcache.sv | 103 ++++++++++
 1 files changed

// File: rtl/jtpang_pcm_romcache.sv
// Direct-mapped byte-read cache between the ADPCM engine and the SDRAM ROM slot.
// Each line holds one 32-bit word; misses are refilled one word at a time.
module jtpang_pcm_romcache #(
  parameter int AW    = 18,
  parameter int LINES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [AW-1:0] pcm_addr,
  output logic [7:0]    pcm_data,
  output logic          pcm_ok,
  output logic [AW-3:0] sdram_addr,
  output logic          sdram_cs,
  input  logic          sdram_ok,
  input  logic [31:0]   sdram_data,
  output logic          busy
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - 2 - IW;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t         st, st_nx;
  logic [AW-1:0]  addr_q;
  logic           hit_q;
  logic           discard;
  logic [AW-3:0]  fill_addr;
  logic [LINES-1:0] valid;
  logic [TW-1:0]  tags  [LINES];
  logic [31:0]    lines [LINES];

  logic [IW-1:0]  idx_in, idx_q, idx_fill;
  logic [TW-1:0]  tag_in, tag_q, tag_fill;
  logic           match_in, miss_q, start, do_write;

  assign idx_in   = pcm_addr[2 +: IW];
  assign tag_in   = pcm_addr[AW-1 -: TW];
  assign idx_q    = addr_q[2 +: IW];
  assign tag_q    = addr_q[AW-1 -: TW];
  assign idx_fill = fill_addr[IW-1:0];
  assign tag_fill = fill_addr[AW-3 -: TW];

  assign match_in = valid[idx_in] && (tags[idx_in] == tag_in);
  assign miss_q   = !(valid[idx_q] && (tags[idx_q] == tag_q));
  assign do_write = (st == WAIT) && sdram_ok && !discard && !flush;

  assign sdram_cs   = (st == WAIT);
  assign busy       = (st == WAIT);
  assign sdram_addr = fill_addr;
  assign pcm_ok     = (pcm_addr == addr_q) && hit_q && !flush;

  // A refill is only launched once the address has been stable for a cycle,
  // so the post-reset addr_q value never triggers a spurious fetch.
  always_comb begin
    st_nx = st;
    start = 1'b0;
    case (st)
      IDLE: if (!flush && miss_q && (pcm_addr == addr_q)) begin
        st_nx = WAIT;
        start = 1'b1;
      end
      WAIT: if (sdram_ok) st_nx = GAP;
      GAP:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // hit_q and pcm_data are looked up with pcm_addr so that they describe addr_q
  // once registered; a line written on this edge is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      addr_q    <= '0;
      hit_q     <= 1'b0;
      pcm_data  <= '0;
      fill_addr <= '0;
      discard   <= 1'b0;
      valid     <= '0;
    end else begin
      st     <= st_nx;
      addr_q <= pcm_addr;
      hit_q  <= match_in && !flush;
      if (match_in && !flush)
        pcm_data <= lines[idx_in][{pcm_addr[1:0], 3'b000} +: 8];
      if (start) begin
        fill_addr <= addr_q[AW-1:2];
        discard   <= 1'b0;
      end
      if (do_write) begin
        valid[idx_fill] <= 1'b1;
        tags[idx_fill]  <= tag_fill;
        lines[idx_fill] <= sdram_data;
      end
      if (flush) begin
        valid <= '0;
        if (st == WAIT) discard <= 1'b1;
      end
    end
  end

endmodule
